// File: rtl/alu_card_sequencer_if.sv
// Request/response channel between control logic and the ALU card sequencer.
// The master issues operations and consumes results; the slave is the sequencer.
interface alu_card_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       req_csel;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_res;
   logic       rsp_sign;
   logic       rsp_z;

   modport master (
      output req_valid, req_op, req_a, req_b, req_csel, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_sign, rsp_z
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_csel, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_sign, rsp_z
   );
endinterface

// File: rtl/alu_card_sequencer.sv
// Launches one operation at a time on the ALU card, waits for its paths to
// settle, captures the result and returns it over a valid/ready response.
module alu_card_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ARITH_CYCLES  = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   alu_card_sequencer_if.slave        bus,
   output logic [7:0]                 alu_a,
   output logic [7:0]                 alu_b,
   output logic [2:0]                 alu_op,
   output logic                       alu_csel,
   input  logic [7:0]                 alu_res,
   input  logic                       alu_sign,
   input  logic                       alu_z,
   output logic [15:0]                ops_done
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] ARITH_LD  = 4'(ARITH_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic [7:0]  res_q;
   logic        sign_q, z_q;
   logic [15:0] done_cnt;
   logic        accept, capture, retire, is_arith;

   // Ready/valid are pure state decodes, so every output stays registered.
   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_res   = res_q;
   assign bus.rsp_sign  = sign_q;
   assign bus.rsp_z     = z_q;
   assign ops_done      = done_cnt;

   assign is_arith = bus.req_op[2] & ~(&bus.req_op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      capture  = 1'b0;
      retire   = 1'b0;
      case (state)
         S_IDLE: if (bus.req_valid) begin
            accept   = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: if (cnt == 4'd0) begin
            capture  = 1'b1;
            state_nx = S_RESP;
         end
         S_RESP: if (bus.rsp_ready) begin
            retire   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         alu_csel <= 1'b0;
         cnt      <= '0;
         res_q    <= '0;
         sign_q   <= 1'b0;
         z_q      <= 1'b0;
         done_cnt <= '0;
      end else begin
         if (accept) begin
            alu_a    <= bus.req_a;
            alu_b    <= bus.req_b;
            alu_op   <= bus.req_op;
            alu_csel <= bus.req_csel;
            cnt      <= is_arith ? ARITH_LD : SETTLE_LD;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            res_q  <= alu_res;
            sign_q <= alu_sign;
            z_q    <= alu_z;
         end
         if (retire && done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_card_sequencer.sv
// Directed bench: two sequencers (default timing and SETTLE=1/ARITH=5), each
// driving a behavioural ALU card model.
module tb_alu_card_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   lat;

   always #5 clk = ~clk;

   alu_card_sequencer_if bus0 ();
   alu_card_sequencer_if bus1 ();

   logic [7:0]  alu_a0, alu_b0, res0, alu_a1, alu_b1, res1;
   logic [2:0]  alu_op0, alu_op1;
   logic        alu_csel0, alu_csel1, sign0, sign1, z0, z1;
   logic [15:0] ops0, ops1;

   alu_card_sequencer dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0),
      .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_csel(alu_csel0),
      .alu_res(res0), .alu_sign(sign0), .alu_z(z0), .ops_done(ops0)
   );

   alu_card_sequencer #(.SETTLE_CYCLES(1), .ARITH_CYCLES(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_csel(alu_csel1),
      .alu_res(res1), .alu_sign(sign1), .alu_z(z1), .ops_done(ops1)
   );

   // Behavioural ALU card
   function automatic logic [7:0] card(input logic [2:0] op, input logic [7:0] a, b,
                                       input logic c);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return ~a;
         3'b011:  return a ^ b;
         3'b100:  return a + b + {7'd0, c};
         3'b101:  return a - b;
         3'b110:  return a - b;
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
      res0  = card(alu_op0, alu_a0, alu_b0, alu_csel0);
      sign0 = res0[7];
      z0    = (res0 == 8'h00);
      res1  = card(alu_op1, alu_a1, alu_b1, alu_csel1);
      sign1 = res1[7];
      z1    = (res1 == 8'h00);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request and count edges until rsp_valid (bounded at 20).
   task automatic run(input bit sel, input logic [2:0] op, input logic [7:0] a, b,
                      input logic c, output int n);
      @(negedge clk);
      if (sel) begin
         bus1.req_op = op; bus1.req_a = a; bus1.req_b = b; bus1.req_csel = c;
         bus1.req_valid = 1'b1;
      end else begin
         bus0.req_op = op; bus0.req_a = a; bus0.req_b = b; bus0.req_csel = c;
         bus0.req_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      bus1.req_valid = 1'b0;
      n = 0;
      while ((sel ? bus1.rsp_valid : bus0.rsp_valid) !== 1'b1 && n < 20) begin
         chk("wait_req_ready", sel ? bus1.req_ready : bus0.req_ready, 0);
         chk("wait_alu_op", sel ? alu_op1 : alu_op0, op);
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic ack(input bit sel);
      @(negedge clk);
      if (sel) bus1.rsp_ready = 1'b1; else bus0.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus0.rsp_ready = 1'b0;
      bus1.rsp_ready = 1'b0;
   endtask

   initial begin
      bus0.req_valid = 0; bus0.req_op = 0; bus0.req_a = 0; bus0.req_b = 0;
      bus0.req_csel = 0; bus0.rsp_ready = 0;
      bus1.req_valid = 0; bus1.req_op = 0; bus1.req_a = 0; bus1.req_b = 0;
      bus1.req_csel = 0; bus1.rsp_ready = 0;

      // Reset state
      #12;
      chk("rst_req_ready", bus0.req_ready, 1);
      chk("rst_rsp_valid", bus0.rsp_valid, 0);
      chk("rst_rsp_res", bus0.rsp_res, 0);
      chk("rst_alu_a", alu_a0, 0);
      chk("rst_alu_op", alu_op0, 0);
      chk("rst_ops_done", ops0, 0);
      @(negedge clk); rst_n = 1'b1;

      // AND: logic timing, 2 edges
      run(0, 3'b000, 8'hF0, 8'h3C, 0, lat);
      chk("and_lat", lat, 2);
      chk("and_res", bus0.rsp_res, 8'h30);
      chk("and_z", bus0.rsp_z, 0);
      ack(0);
      chk("and_ops", ops0, 1);

      // ADD with backpressure and an ignored request
      run(0, 3'b100, 8'h7F, 8'h01, 0, lat);
      chk("add_lat", lat, 3);
      chk("add_res", bus0.rsp_res, 8'h80);
      chk("add_sign", bus0.rsp_sign, 1);
      chk("add_z", bus0.rsp_z, 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            @(negedge clk);
            bus0.req_op = 3'b000; bus0.req_a = 8'h11; bus0.req_b = 8'h22;
            bus0.req_valid = 1'b1;
            @(posedge clk); #1;
            bus0.req_valid = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
         chk("bp_rsp_valid", bus0.rsp_valid, 1);
         chk("bp_rsp_res", bus0.rsp_res, 8'h80);
         chk("bp_req_ready", bus0.req_ready, 0);
         chk("bp_alu_a", alu_a0, 8'h7F);
         chk("bp_alu_b", alu_b0, 8'h01);
         chk("bp_alu_op", alu_op0, 3'b100);
      end
      ack(0);
      chk("bp_ops", ops0, 2);
      chk("bp_idle_ready", bus0.req_ready, 1);
      chk("bp_idle_valid", bus0.rsp_valid, 0);
      chk("idle_res_hold", bus0.rsp_res, 8'h80);
      chk("ignored_alu_a", alu_a0, 8'h7F);

      // SUB to zero
      run(0, 3'b101, 8'h05, 8'h05, 0, lat);
      chk("sub_lat", lat, 3);
      chk("sub_res", bus0.rsp_res, 8'h00);
      chk("sub_z", bus0.rsp_z, 1);
      ack(0);
      chk("sub_ops", ops0, 3);

      // Async reset in the middle of WAIT
      @(negedge clk);
      bus0.req_op = 3'b101; bus0.req_a = 8'h09; bus0.req_b = 8'h03;
      bus0.req_valid = 1'b1;
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_req_ready", bus0.req_ready, 1);
      chk("arst_rsp_valid", bus0.rsp_valid, 0);
      chk("arst_rsp_z", bus0.rsp_z, 0);
      chk("arst_alu_a", alu_a0, 0);
      chk("arst_alu_op", alu_op0, 0);
      chk("arst_ops", ops0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("arst_no_rsp", bus0.rsp_valid, 0);
      end

      // Normal operation resumes
      run(0, 3'b001, 8'h0F, 8'hA0, 0, lat);
      chk("or_lat", lat, 2);
      chk("or_res", bus0.rsp_res, 8'hAF);
      chk("or_sign", bus0.rsp_sign, 1);
      ack(0);
      chk("or_ops", ops0, 1);

      run(0, 3'b111, 8'hAA, 8'h55, 0, lat);
      chk("shift_lat", lat, 2);
      chk("shift_res", bus0.rsp_res, 8'h00);
      chk("shift_z", bus0.rsp_z, 1);
      ack(0);

      run(0, 3'b110, 8'h03, 8'h05, 0, lat);
      chk("cmp_lat", lat, 3);
      chk("cmp_res", bus0.rsp_res, 8'hFE);
      chk("cmp_sign", bus0.rsp_sign, 1);
      chk("cmp_z", bus0.rsp_z, 0);
      ack(0);
      chk("cmp_ops", ops0, 3);

      // Saturation of the completion counter
      @(negedge clk);
      force dut0.done_cnt = 16'hFFFE;
      @(negedge clk);
      release dut0.done_cnt;
      #1;
      chk("sat_preload", ops0, 16'hFFFE);
      run(0, 3'b000, 8'h01, 8'h01, 0, lat);
      ack(0);
      chk("sat_reach", ops0, 16'hFFFF);
      run(0, 3'b000, 8'h01, 8'h01, 0, lat);
      ack(0);
      chk("sat_hold", ops0, 16'hFFFF);

      // Alternate timing instance
      run(1, 3'b011, 8'h55, 8'h0F, 0, lat);
      chk("p_xor_lat", lat, 1);
      chk("p_xor_res", bus1.rsp_res, 8'h5A);
      ack(1);
      run(1, 3'b110, 8'h05, 8'h05, 0, lat);
      chk("p_cmp_lat", lat, 5);
      chk("p_cmp_z", bus1.rsp_z, 1);
      chk("p_cmp_sign", bus1.rsp_sign, 0);
      ack(1);
      chk("p_ops", ops1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_card_sequencer.md
Name: alu_card_sequencer

Overview:
- Initiator-side controller for the 8-bit ALU card: accepts one operation at a time over a valid/ready request channel and drives the card's a, b, op and csel inputs from registers.
- Waits a programmable number of clocks for the card's gate-level paths to settle, then captures res, sign and z into registers.
- Returns the captured result over a valid/ready response channel.
- Sits between the instruction/control logic and the ALU card; the only path by which control logic launches ALU operations.

Parameters:
- SETTLE_CYCLES, 2, clocks from launch to capture for logic ops (op 000-011, 111); legal range 1-15.
- ARITH_CYCLES, 3, clocks from launch to capture for add/sub/cmp (op 100-110); covers the card's internal adder register; legal range 1-15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  operation code
- req_a  in  8  operand a
- req_b  in  8  operand b
- req_csel  in  1  carry-select passed to card
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_res  out  8  captured result
- rsp_sign  out  1  captured sign
- rsp_z  out  1  captured zero flag
- alu_a  out  8  to card a
- alu_b  out  8  to card b
- alu_op  out  3  to card op
- alu_csel  out  1  to card csel
- alu_res  in  8  from card res
- alu_sign  in  1  from card sign
- alu_z  in  1  from card z
- ops_done  out  16  count of completed responses, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - req_ready=1, rsp_valid=0.
  - rsp_res=0, rsp_sign=0, rsp_z=0.
  - alu_a=0, alu_b=0, alu_op=000, alu_csel=0.
  - ops_done=0.
- Reset asserted mid-operation aborts immediately: no response is produced and the counter returns to 0.
- Op encoding:
  - 000 AND, 001 OR, 010 NOT, 011 XOR.
  - 100 ADD, 101 SUB, 110 CMP.
  - 111 SHIFT: card returns 0, still sequenced normally.
- State machine IDLE / WAIT / RESP:
  - IDLE: req_ready=1. On a rising edge with req_valid=1:
    - register req_a/b/op/csel onto alu_a/b/op/alu_csel;
    - load the 4-bit counter with N-1, where N = ARITH_CYCLES for op 100-110, else SETTLE_CYCLES;
    - go to WAIT.
  - WAIT: req_ready=0, alu_* held constant.
    - Count is nonzero: decrement.
    - Count is zero: on that edge capture alu_res/sign/z into rsp_*, set rsp_valid=1, go to RESP.
  - RESP: req_ready=0. rsp_* and alu_* held stable while rsp_ready=0.
    - Edge with rsp_ready=1: rsp_valid=0, ops_done increments (holds at 0xFFFF), go to IDLE.
- Latency: rsp_valid rises exactly N clock edges after the accepting edge.
  - Example: ADD accepted at edge 0 gives rsp_valid high after edge 3.
- Throughput: one operation per N+2 cycles minimum. No overlap, because the response and next accept never share an edge.
- req_valid while req_ready=0 is ignored; nothing is queued.
- Request fields are sampled only on the accepting edge.
- CMP: rsp_res is whatever the card drives. Consumers use sign/z only; the sequencer does not mask it.
- rsp_* retain their last value in IDLE and WAIT. They change only on a capture edge or on reset.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- AND, req_a=0xF0, req_b=0x3C, card model returns 0xF0&0x3C -> rsp_valid after exactly 2 edges, rsp_res=0x30, rsp_z=0; alu_op=000 held throughout WAIT.
- ADD, req_a=0x7F, req_b=0x01, csel=0 -> rsp_valid after exactly 3 edges, rsp_res=0x80, rsp_sign=1, rsp_z=0.
- SUB 0x05-0x05 -> rsp_res=0x00, rsp_z=1.
- Backpressure:
  - hold rsp_ready=0 for 5 cycles after rsp_valid;
  - rsp_* and alu_* stay stable, req_ready stays 0;
  - a second req_valid pulse (AND 0x11, 0x22) is ignored;
  - on rsp_ready=1, return to IDLE, ops_done=1.
- Async reset: assert rst_n=0 mid-WAIT of a SUB, between clock edges -> all outputs reach reset values without a clock edge; no rsp_valid after release; next request sequences normally.
- Parameter/saturation:
  - SETTLE_CYCLES=1, ARITH_CYCLES=5: XOR responds 1 edge after accept, CMP 5 edges after accept.
  - Preload ops_done near 0xFFFF, or run 65540 ops: holds at 0xFFFF.
